// File: rtl/restador_pkg.sv
// Shared constants and types for the debounced down-counter.
// Contents: default parameter values, the counter-width helper used by the
// debounce and auto-repeat counters, and the underflow-mode encoding.
package restador_pkg;

    localparam int unsigned N_DEF             = 4;
    localparam int unsigned STEP_DEF          = 1;
    localparam int unsigned DB_CYCLES_DEF     = 4;
    localparam int unsigned REPEAT_DELAY_DEF  = 16;
    localparam int unsigned REPEAT_PERIOD_DEF = 4;

    // Underflow behaviour selected by the SATURATE parameter
    typedef enum logic {
        OVF_WRAP     = 1'b0,
        OVF_SATURATE = 1'b1
    } ovf_mode_e;

    // Bits needed to hold a count up to max_count (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, stability counter and falling-edge pulse for one raw
// active-low button.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_btn_n   - raw asynchronous button, low = pressed
//   o_level   - debounced level (1 = released)
//   o_fall    - one-cycle pulse when the debounced level goes 1 -> 0
module btn_debounce
    import restador_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Level flips once the synchronised input has disagreed with it for
    // DB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/restador_debounced.sv
// Parametrised down-counter driven by two debounced active-low buttons.
// A btn_rst press loads data_in; a btn_sub press subtracts STEP, wrapping
// or saturating on underflow with a one-cycle borrow pulse.
// Optional feature: define RESTADOR_AUTOREPEAT_EN to make a held btn_sub
// repeat after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   btn_rst, btn_sub  - raw active-low load / subtract buttons
//   data_in  [N-1:0]  - load value
//   data_out [N-1:0]  - registered counter value
//   zero              - data_out == 0
//   borrow            - one-cycle pulse on an underflowing subtract
module restador_debounced
    import restador_pkg::*;
#(
    parameter int unsigned N             = N_DEF,
    parameter int unsigned STEP          = STEP_DEF,
    parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
    parameter int unsigned SATURATE      = 0,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_rst,
    input  logic         btn_sub,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out,
    output logic         zero,
    output logic         borrow
);

    localparam ovf_mode_e OVF_MODE = (SATURATE != 0) ? OVF_SATURATE : OVF_WRAP;
    localparam bit CFG_BAD = (DB_CYCLES == 0) || (STEP == 0) ||
                             (STEP >= (32'd1 << N)) ||
                             (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0);

    if (CFG_BAD) begin : g_cfg_bad
        $error("restador_debounced: illegal parameter set");
    end

    logic w_ld_lvl;
    logic w_ld_fall;
    logic w_sub_lvl;
    logic w_sub_fall;
    logic w_sub_ev;
    logic w_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (btn_rst),
        .o_level (w_ld_lvl),
        .o_fall  (w_ld_fall)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sub (
        .clk     (clk),
        .rst     (rst),
        .i_btn_n (btn_sub),
        .o_level (w_sub_lvl),
        .o_fall  (w_sub_fall)
    );

`ifdef RESTADOR_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RW      = cnt_width(RPT_MAX);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_first;
    logic          w_rpt_hit;

    // r_rpt_cnt = cycles since the last subtract event while held
    assign w_rpt_hit = ~w_sub_lvl & ~w_sub_fall &
                       (r_rpt_cnt == (r_rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_sub_fall) begin
            r_rpt_cnt   <= RW'(1);
            r_rpt_first <= 1'b1;
        end else if (w_sub_lvl) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_hit) begin
            r_rpt_cnt   <= RW'(1);
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end
    end

    assign w_sub_ev = w_sub_fall | w_rpt_hit;
    assign w_unused = w_ld_lvl;
`else
    assign w_sub_ev = w_sub_fall;
    assign w_unused = w_ld_lvl ^ w_sub_lvl;
`endif

    logic [N-1:0] r_data;
    logic         r_borrow;

    // Load has priority; an underflowing subtract flags borrow for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_borrow <= 1'b0;
            if (w_ld_fall) begin
                r_data <= data_in;
            end else if (w_sub_ev) begin
                if (r_data >= N'(STEP)) begin
                    r_data <= r_data - N'(STEP);
                end else begin
                    r_data   <= (OVF_MODE == OVF_SATURATE) ? '0 : (r_data - N'(STEP));
                    r_borrow <= 1'b1;
                end
            end
        end
    end

    assign data_out = r_data;
    assign borrow   = r_borrow;
    assign zero     = (r_data == '0);

endmodule
